// File: rtl/ws2812b_pixel_capture.sv
// Purpose: assemble decoded WS2812B bits into 24-bit GRB pixels, track frame position and latch gap, and capture one selected pixel.
// Latency: 1 cycle from the 24th bit_valid edge to pixel_done/pixel_grb/cap_*; frame_done appears LATCH_CYCLES+1 edges after the last bit.
// Backpressure: none; a bit is accepted on every cycle bit_valid is high, back-to-back included.
//
// Ports:
//   clk, rst_n              system clock, asynchronous active-low reset
//   bit_valid, bit_value    decoded bit strobe and value from the pulse decoder
//   pixel_sel               pixel index to capture, latched at the start of each frame
//   pixel_done/_index/_grb  per-pixel pulse, its index (saturating at 255) and {G,R,B} word
//   cap_g/_r/_b, cap_valid  captured colour of the selected pixel and its update flag
//   frame_done              one-cycle pulse when the latch gap ends a frame
//   frame_partial           last ended frame finished with an incomplete pixel
//   overflow                pixel counter saturated in the current/last frame
`timescale 1ns/1ps

module ws2812b_pixel_capture #(
    parameter int CLK_HZ       = 64000000,
    parameter int LATCH_CYCLES = 3200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bit_valid,
    input  logic        bit_value,
    input  logic [7:0]  pixel_sel,
    output logic        pixel_done,
    output logic [7:0]  pixel_index,
    output logic [23:0] pixel_grb,
    output logic [7:0]  cap_g,
    output logic [7:0]  cap_r,
    output logic [7:0]  cap_b,
    output logic        cap_valid,
    output logic        frame_done,
    output logic        frame_partial,
    output logic        overflow
);

    // CLK_HZ only documents the intended clock; it takes part in the parameter sanity check.
    if (CLK_HZ <= 0 || LATCH_CYCLES < 2 || LATCH_CYCLES > 65535) begin : g_param_check
        $error("ws2812b_pixel_capture: illegal CLK_HZ or LATCH_CYCLES");
    end

    localparam logic [15:0] LATCH_LIM = 16'(LATCH_CYCLES);
    localparam logic [4:0]  LAST_BIT  = 5'd23;
    localparam logic [7:0]  PIX_MAX   = 8'd255;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RECV = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [23:0] r_sh;
    logic [4:0]  r_bit_cnt;
    logic [7:0]  r_pix_cnt;
    logic [7:0]  r_sel;
    logic [15:0] r_idle_cnt;

    logic        r_pixel_done;
    logic [7:0]  r_pixel_index;
    logic [23:0] r_pixel_grb;
    logic [7:0]  r_cap_g;
    logic [7:0]  r_cap_r;
    logic [7:0]  r_cap_b;
    logic        r_cap_valid;
    logic        r_frame_done;
    logic        r_frame_partial;
    logic        r_overflow;

    logic        w_start;
    logic        w_timeout;
    logic        w_last_bit;
    logic [23:0] w_word;

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bit_valid) w_state_nxt = S_RECV;
            S_RECV:  if (w_timeout) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: output decode. A bit arriving on the timeout edge keeps the
    // frame alive, so the timeout is qualified by the absence of a bit.
    // ---------------------------------------------------------------
    always_comb begin
        w_start   = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE:  w_start   = bit_valid;
            S_RECV:  w_timeout = !bit_valid && (r_idle_cnt == LATCH_LIM);
            default: begin
                w_start   = 1'b0;
                w_timeout = 1'b0;
            end
        endcase
    end

    assign w_last_bit = bit_valid && (r_bit_cnt == LAST_BIT);
    assign w_word     = {r_sh[22:0], bit_value};

    // ---------------------------------------------------------------
    // Idle counter: free-running in both states, saturating at the
    // latch length so it never wraps back into a false gap.
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_cnt <= 16'd0;
        end else if (bit_valid) begin
            r_idle_cnt <= 16'd0;
        end else if (r_idle_cnt != LATCH_LIM) begin
            r_idle_cnt <= r_idle_cnt + 16'd1;
        end
    end

    // ---------------------------------------------------------------
    // Bit assembly, pixel counting and capture
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh            <= 24'd0;
            r_bit_cnt       <= 5'd0;
            r_pix_cnt       <= 8'd0;
            r_sel           <= 8'd0;
            r_pixel_done    <= 1'b0;
            r_pixel_index   <= 8'd0;
            r_pixel_grb     <= 24'd0;
            r_cap_g         <= 8'd0;
            r_cap_r         <= 8'd0;
            r_cap_b         <= 8'd0;
            r_cap_valid     <= 1'b0;
            r_frame_done    <= 1'b0;
            r_frame_partial <= 1'b0;
            r_overflow      <= 1'b0;
        end else begin
            r_pixel_done <= 1'b0;
            r_frame_done <= 1'b0;

            if (w_timeout) begin
                // End of frame: any trailing partial pixel is dropped.
                r_frame_done    <= 1'b1;
                r_frame_partial <= (r_bit_cnt != 5'd0);
                r_bit_cnt       <= 5'd0;
                r_pix_cnt       <= 8'd0;
                r_sh            <= 24'd0;
            end else if (bit_valid) begin
                if (w_start) begin
                    // Selection is frozen for the whole frame.
                    r_sel       <= pixel_sel;
                    r_cap_valid <= 1'b0;
                    r_overflow  <= 1'b0;
                end

                r_sh <= w_word;

                if (w_last_bit) begin
                    r_bit_cnt     <= 5'd0;
                    r_pixel_grb   <= w_word;
                    r_pixel_index <= r_pix_cnt;
                    r_pixel_done  <= 1'b1;

                    // Once saturated, index 255 no longer names a unique pixel.
                    if ((r_pix_cnt == r_sel) && !r_overflow) begin
                        r_cap_g     <= w_word[23:16];
                        r_cap_r     <= w_word[15:8];
                        r_cap_b     <= w_word[7:0];
                        r_cap_valid <= 1'b1;
                    end

                    if (r_pix_cnt == PIX_MAX) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_pix_cnt <= r_pix_cnt + 8'd1;
                    end
                end else begin
                    r_bit_cnt <= r_bit_cnt + 5'd1;
                end
            end
        end
    end

    assign pixel_done    = r_pixel_done;
    assign pixel_index   = r_pixel_index;
    assign pixel_grb     = r_pixel_grb;
    assign cap_g         = r_cap_g;
    assign cap_r         = r_cap_r;
    assign cap_b         = r_cap_b;
    assign cap_valid     = r_cap_valid;
    assign frame_done    = r_frame_done;
    assign frame_partial = r_frame_partial;
    assign overflow      = r_overflow;

endmodule
